pmem_arbiter: RTL and testbench
===============================

Name: pmem_arbiter

Overview:
- Parametrised N-client arbiter between the per-client caches (I-cache, D-cache, later L2/prefetch) and the single physical memory port.
- Clients use the same read/write/resp cacheline handshake the caches already present to pmem.
- Round-robin fairness; one outstanding pmem transaction at a time; request latched at grant so pmem sees stable signals.

Parameters:
NUM_PORTS, 2, number of client ports (>=2)
ADDR_WIDTH, 16, address width in bits (lc3b_word)
LINE_WIDTH, 128, cacheline width in bits (lc3b_cacheline)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
cli_read  input  NUM_PORTS  per-client read request, held until its cli_resp bit
cli_write  input  NUM_PORTS  per-client write request, held until its cli_resp bit
cli_address  input  NUM_PORTS*ADDR_WIDTH  client i address at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
cli_wdata  input  NUM_PORTS*LINE_WIDTH  client i write line at bits [i*LINE_WIDTH +: LINE_WIDTH]
cli_resp  output  NUM_PORTS  one-hot completion pulse to the granted client
cli_rdata  output  LINE_WIDTH  read line, shared by all clients, valid only with cli_resp
pmem_resp  input  1  physical memory completion
pmem_rdata  input  LINE_WIDTH  physical memory read line
pmem_read  output  1  physical memory read strobe
pmem_write  output  1  physical memory write strobe
pmem_address  output  ADDR_WIDTH  physical memory address
pmem_wdata  output  LINE_WIDTH  physical memory write line

Behaviour:
- Reset (async, rst_n=0): state=IDLE; last_grant=NUM_PORTS-1, so port 0 has first priority; pmem_read=pmem_write=0; pmem_address=0; pmem_wdata=0; cli_resp=0. Outputs take these values immediately, independent of clk.
- Valid request from client i: cli_read[i] | cli_write[i]. If both are set, the request is treated as a write.
- IDLE:
  - If any request is valid, grant the first requesting index scanning last_grant+1, last_grant+2, ... with modulo NUM_PORTS wrap.
  - Latch grant index, op, address and wdata into registers; set last_grant=grant; next state BUSY.
  - With no valid request, remain in IDLE.
- BUSY:
  - pmem_read/pmem_write are driven from the latched op.
  - pmem_address and pmem_wdata are driven from the latched registers and held stable for the whole transaction.
  - On pmem_resp=1: cli_resp[grant]=pmem_resp combinationally in that cycle; cli_rdata=pmem_rdata combinationally; next state DONE.
- DONE:
  - One bubble cycle with pmem strobes low and cli_resp=0, giving the client time to drop its request; next state IDLE.
- Latency:
  - Request visible at edge k (arbiter in IDLE) -> pmem strobe asserted from cycle k+1.
  - cli_resp occurs in the same cycle as pmem_resp.
  - Back-to-back grants are at least 3 cycles apart (IDLE, BUSY>=1, DONE).
- cli_resp is 0 in IDLE and DONE, and 0 on every non-granted bit at all times.
- A client dropping its request while BUSY does not abort the transaction: it completes, and cli_resp still pulses to that index.
- Latched address/wdata ignore client input changes after grant.
- A request arriving in BUSY or DONE waits; it is arbitrated in the next IDLE cycle.
- Round-robin guarantee: a continuously requesting client is granted within NUM_PORTS grants.
- pmem_resp while IDLE or DONE is ignored: no cli_resp, no state change.
- Reset mid-transaction (rst_n low in BUSY): strobes drop immediately, state goes to IDLE, the priority pointer is reinitialised, and the in-flight request is lost; clients re-issue.

Test Plan:
- Single read: port 1 reads 0x1230; pmem_resp after 4 cycles with rdata 0xDEAD...BEEF -> pmem_read=1 with address 0x1230 from cycle after request; cli_resp=2'b10 for exactly one cycle with cli_rdata=0xDEAD...BEEF; DONE then IDLE.
- Collision after reset: ports 0 and 1 request same cycle -> port 0 served first, then port 1. Port 0 re-requests immediately -> port 1 still precedes port 0's second grant.
- NUM_PORTS=4: all ports request continuously -> grant order 0,1,2,3,0; no port waits more than 4 grants.
- Write with input change: port 0 writes 0x0040 with wdata W; client changes cli_wdata mid-BUSY -> pmem_wdata stays W and pmem_address stays 0x0040 until pmem_resp; pmem_read=0 throughout.
- Read and write both set on port 1 -> pmem_write asserted, pmem_read=0.
- Reset and stray resp: rst_n pulsed low during BUSY -> pmem_read drops without a clk edge; after release, port 0 priority restored. Spurious pmem_resp in IDLE -> cli_resp stays 0.

Source files
------------

// File: rtl/pmem_arbiter_if.sv
// Client-side and pmem-side bus bundle for the pmem arbiter.
// The arbiter takes the slave view; clients plus memory take the master view.
interface pmem_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
);
    logic [NUM_PORTS-1:0]            cli_read;
    logic [NUM_PORTS-1:0]            cli_write;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] cli_address;
    logic [NUM_PORTS*LINE_WIDTH-1:0] cli_wdata;
    logic [NUM_PORTS-1:0]            cli_resp;
    logic [LINE_WIDTH-1:0]           cli_rdata;
    logic                            pmem_resp;
    logic [LINE_WIDTH-1:0]           pmem_rdata;
    logic                            pmem_read;
    logic                            pmem_write;
    logic [ADDR_WIDTH-1:0]           pmem_address;
    logic [LINE_WIDTH-1:0]           pmem_wdata;

    modport slave (
        input  cli_read, cli_write, cli_address, cli_wdata,
        input  pmem_resp, pmem_rdata,
        output cli_resp, cli_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output cli_read, cli_write, cli_address, cli_wdata,
        output pmem_resp, pmem_rdata,
        input  cli_resp, cli_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin N-client arbiter in front of the single physical memory port.
// One transaction in flight; the winning request is latched at grant.
module pmem_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    pmem_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_W-1:0]      r_last_grant;
    logic                  r_is_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_WIDTH-1:0] r_wdata;

    logic [NUM_PORTS-1:0]  w_req;
    logic                  w_found;
    logic [IDX_W-1:0]      w_pick;
    logic                  w_pick_write;
    logic [ADDR_WIDTH-1:0] w_pick_addr;
    logic [LINE_WIDTH-1:0] w_pick_wdata;
    logic                  w_take;

    assign w_req  = bus.cli_read | bus.cli_write;
    assign w_take = (r_state == S_IDLE) && w_found;

    // Round-robin pick: indices above the last grant first, then wrap around.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last_grant;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!w_found && w_req[i] && (IDX_W'(i) > r_last_grant)) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!w_found && w_req[i] && (IDX_W'(i) <= r_last_grant)) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(i);
            end
        end
    end

    // Select the picked client's op, address and line; write wins over read.
    always_comb begin
        w_pick_write = 1'b0;
        w_pick_addr  = '0;
        w_pick_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (IDX_W'(i) == w_pick) begin
                w_pick_write = bus.cli_write[i];
                w_pick_addr  = bus.cli_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_pick_wdata = bus.cli_wdata[i*LINE_WIDTH +: LINE_WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, pmem strobes and the completion pulse to the granted client.
    always_comb begin
        w_state_nxt    = r_state;
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        bus.cli_resp   = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                bus.pmem_read  = ~r_is_write;
                bus.pmem_write = r_is_write;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    bus.cli_resp[i] = bus.pmem_resp &&
                                      (IDX_W'(i) == r_last_grant);
                end
                if (bus.pmem_resp) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Latch the winning request and move the priority pointer at grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= IDX_W'(NUM_PORTS - 1);
            r_is_write   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else if (w_take) begin
            r_last_grant <= w_pick;
            r_is_write   <= w_pick_write;
            r_addr       <= w_pick_addr;
            r_wdata      <= w_pick_wdata;
        end
    end

    assign bus.pmem_address = r_addr;
    assign bus.pmem_wdata   = r_wdata;
    assign bus.cli_rdata    = bus.pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Randomised scoreboard bench for pmem_arbiter with four clients.
// Issued requests are queued; a negedge monitor predicts and checks grants.
module tb_pmem_arbiter;
    localparam int NP = 4;
    localparam int AW = 16;
    localparam int LW = 128;

    typedef struct {
        int            cli;
        logic          w;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } exp_t;

    typedef enum logic [1:0] {PH_IDLE, PH_BUSY, PH_DONE} ph_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pmem_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

    pmem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t          sb[$];
    int            done_q[$];
    int            n_chk = 0;
    int            n_pass = 0;
    int            n_txn = 0;
    logic [NP-1:0] busy_c = '0;
    logic [LW-1:0] drv_rdata = '0;
    logic [LW-1:0] fix_rd = 128'hDEAD_1111_2222_3333_4444_5555_6666_BEEF;
    bit            fix_rd_en = 0;
    int            fix_dly = -1;
    bit            armed = 0;
    int            cnt = 0;
    bit            rnd_en = 0;
    int            rnd_pct = 0;

    function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endfunction

    // Spec rule: first requester scanning last+1, last+2, ... modulo NP.
    function automatic int rr_pick(logic [NP-1:0] req, int last);
        for (int k = 1; k <= NP; k++)
            if (req[(last + k) % NP]) return (last + k) % NP;
        return -1;
    endfunction

    function automatic int sb_find(int c);
        for (int j = 0; j < sb.size(); j++)
            if (sb[j].cli == c) return j;
        return -1;
    endfunction

    task automatic issue(int i, int op, logic [AW-1:0] a, logic [LW-1:0] d);
        exp_t e;
        bus.cli_read[i] = (op == 0 || op == 2);
        bus.cli_write[i] = (op != 0);
        bus.cli_address[i*AW +: AW] = a;
        bus.cli_wdata[i*LW +: LW] = d;
        busy_c[i] = 1'b1;
        e.cli = i;
        e.w = (op != 0);
        e.addr = a;
        e.wdata = d;
        sb.push_back(e);
    endtask

    task automatic drop(int i);
        bus.cli_read[i] = 1'b0;
        bus.cli_write[i] = 1'b0;
    endtask

    task automatic pmem_tick();
        if (bus.pmem_resp) begin
            bus.pmem_resp = 1'b0;
        end else begin
            if (!armed && (bus.pmem_read || bus.pmem_write)) begin
                armed = 1;
                cnt = (fix_dly >= 0) ? fix_dly : int'($urandom_range(3));
            end
            if (armed) begin
                if (cnt == 0) begin
                    drv_rdata = fix_rd_en ? fix_rd
                              : {$urandom, $urandom, $urandom, $urandom};
                    bus.pmem_rdata = drv_rdata;
                    bus.pmem_resp = 1'b1;
                    armed = 0;
                end else begin
                    cnt--;
                end
            end
        end
    endtask

    task automatic step();
        int c;
        @(posedge clk);
        #1;
        while (done_q.size() > 0) begin
            c = done_q.pop_front();
            drop(c);
            busy_c[c] = 1'b0;
        end
        if (rnd_en)
            for (int i = 0; i < NP; i++)
                if (!busy_c[i] && $urandom_range(99) < rnd_pct)
                    issue(i, int'($urandom_range(2)), AW'($urandom),
                          {$urandom, $urandom, $urandom, $urandom});
        pmem_tick();
    endtask

    task automatic wait_all(int max);
        int t = 0;
        while (busy_c != '0 && t < max) begin
            step();
            t++;
        end
        chk("drain_timeout", 256'(busy_c), 256'(0));
        step();
        step();
    endtask

    task automatic wait_strobe(int max);
        int t = 0;
        while (!(bus.pmem_read || bus.pmem_write) && t < max) begin
            step();
            t++;
        end
        chk("strobe_timeout", 256'(bus.pmem_read | bus.pmem_write), 256'(1));
    endtask

    // Monitor: predict this cycle's phase from the previous one and check it.
    ph_t           ph = PH_IDLE;
    logic [NP-1:0] prev_req = '0;
    bit            prev_resp = 0;
    int            m_last = NP - 1;
    int            m_g = 0;
    exp_t          cur;

    always @(negedge clk) begin : mon
        logic          st;
        logic [NP-1:0] oh;
        int            k;
        ph_t           cur_ph;
        if (!rst_n) begin
            ph = PH_IDLE;
            prev_req = '0;
            prev_resp = 0;
            m_last = NP - 1;
        end else begin
            st = bus.pmem_read | bus.pmem_write;
            case (ph)
                PH_IDLE: cur_ph = (prev_req != '0) ? PH_BUSY : PH_IDLE;
                PH_BUSY: cur_ph = prev_resp ? PH_DONE : PH_BUSY;
                default: cur_ph = PH_IDLE;
            endcase
            if (ph == PH_IDLE && prev_req != '0) begin
                m_g = rr_pick(prev_req, m_last);
                m_last = m_g;
                k = sb_find(m_g);
                chk("sb_entry_found", 256'(k >= 0), 256'(1));
                if (k >= 0) cur = sb[k];
            end
            if (cur_ph == PH_BUSY) begin
                chk("busy_bus",
                    256'({bus.pmem_read, bus.pmem_write,
                          bus.pmem_address, bus.pmem_wdata}),
                    256'({~cur.w, cur.w, cur.addr, cur.wdata}));
                if (bus.pmem_resp) begin
                    oh = '0;
                    oh[m_g] = 1'b1;
                    chk("cli_resp", 256'(bus.cli_resp), 256'(oh));
                    chk("cli_rdata", 256'(bus.cli_rdata), 256'(drv_rdata));
                    k = sb_find(m_g);
                    if (k >= 0) sb.delete(k);
                    done_q.push_back(m_g);
                    n_txn++;
                end else begin
                    chk("resp_early", 256'(bus.cli_resp), 256'(0));
                end
            end else begin
                chk("quiet", 256'({st, bus.cli_resp}), 256'(0));
            end
            prev_resp = (cur_ph == PH_BUSY) && bus.pmem_resp;
            prev_req = bus.cli_read | bus.cli_write;
            ph = cur_ph;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int t;
        bus.cli_read = '0;
        bus.cli_write = '0;
        bus.cli_address = '0;
        bus.cli_wdata = '0;
        bus.pmem_resp = 1'b0;
        bus.pmem_rdata = '0;
        #3;
        chk("rst_read", 256'(bus.pmem_read), 256'(0));
        chk("rst_write", 256'(bus.pmem_write), 256'(0));
        chk("rst_addr", 256'(bus.pmem_address), 256'(0));
        chk("rst_wdata", 256'(bus.pmem_wdata), 256'(0));
        chk("rst_resp", 256'(bus.cli_resp), 256'(0));
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single read on port 1.
        fix_dly = 3;
        fix_rd_en = 1;
        issue(1, 0, 16'h1230, '0);
        step();
        chk("read_latency",
            256'({bus.pmem_read, bus.pmem_write, bus.pmem_address}),
            256'({1'b1, 1'b0, 16'h1230}));
        wait_all(50);
        fix_rd_en = 0;

        // Collision after reset-like pointer: port 0 then 1, then 0 again.
        fix_dly = 1;
        issue(0, 0, 16'h0A00, '0);
        issue(1, 0, 16'h0B00, '0);
        t = 0;
        while (busy_c[0] && t < 50) begin
            step();
            t++;
        end
        issue(0, 0, 16'h0A10, '0);
        wait_all(80);

        // All four ports requesting continuously.
        fix_dly = 0;
        rnd_pct = 100;
        rnd_en = 1;
        n0 = n_txn;
        t = 0;
        while (n_txn < n0 + 9 && t < 200) begin
            step();
            t++;
        end
        chk("cont_progress", 256'(n_txn >= n0 + 9), 256'(1));
        rnd_en = 0;
        wait_all(100);

        // Write with client inputs changing mid-transaction.
        fix_dly = 4;
        issue(0, 1, 16'h0040, 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978);
        wait_strobe(20);
        step();
        bus.cli_address[0 +: AW] = 16'hFFFF;
        bus.cli_wdata[0 +: LW] = '1;
        wait_all(50);

        // Read and write both set on port 1.
        fix_dly = 1;
        issue(1, 2, 16'h2222, {4{32'hCAFE_F00D}});
        step();
        chk("both_is_write", 256'({bus.pmem_read, bus.pmem_write}),
            256'(2'b01));
        wait_all(50);

        // Port 3 drops its request while busy; completion still reaches it.
        fix_dly = 3;
        issue(3, 0, 16'h3300, '0);
        wait_strobe(20);
        step();
        drop(3);
        wait_all(50);

        // Randomised traffic.
        fix_dly = -1;
        rnd_pct = 30;
        rnd_en = 1;
        repeat (1500) step();
        rnd_en = 0;
        wait_all(400);

        // Stray pmem_resp while idle.
        bus.pmem_resp = 1'b1;
        #1;
        chk("stray_resp", 256'(bus.cli_resp), 256'(0));
        step();
        step();

        // Reset during BUSY: pointer at 1, then ports 0 and 2 compete.
        fix_dly = 6;
        issue(0, 0, 16'h0500, '0);
        wait_all(50);
        issue(1, 0, 16'h0600, '0);
        wait_strobe(20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_drop", 256'({bus.pmem_read, bus.pmem_write}), 256'(0));
        bus.cli_read = '0;
        bus.cli_write = '0;
        busy_c = '0;
        sb.delete();
        done_q.delete();
        armed = 0;
        bus.pmem_resp = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        fix_dly = 1;
        issue(0, 0, 16'h0700, '0);
        issue(2, 0, 16'h0800, '0);
        step();
        chk("prio_after_rst", 256'(bus.pmem_address), 256'(16'h0700));
        wait_all(80);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
